lcd_bcd_writer: RTL and testbench



---
 rtl/lcd_bcd_writer_pkg.sv | 73 +++++++
 rtl/lcd_bcd_writer_if.sv | 29 ++
 rtl/lcd_bcd_writer_xfer.sv | 117 +++++++++++
 rtl/lcd_bcd_writer.sv | 190 +++++++++++++++++++
 tb/tb_lcd_bcd_writer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_bcd_writer_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants, enums and formatting helpers for the BCD-to-LCD writer.
//   - HD44780 command bytes used by the init sequence and line addressing
//   - ASCII codes for the characters the writer can emit
//   - top-level FSM state and byte-transfer phase enums
//   - init_cmd()  : n-th byte of the power-up command sequence
//   - fmt_digit() : BCD digit -> ASCII, including leading-zero blanking
// ---------------------------------------------------------------------------
package lcd_pkg;

   localparam logic [7:0] LCD_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;  // display on, no cursor, no blink
   localparam logic [7:0] LCD_CLEAR     = 8'h01;  // clear display, needs the long wait
   localparam logic [7:0] LCD_ENTRY     = 8'h06;  // increment address, no shift
   localparam logic [7:0] LCD_SET_DDRAM = 8'h80;  // OR with a 7-bit DDRAM address

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   localparam int N_INIT_CMDS = 4;

   typedef enum logic [1:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_DRAW
   } top_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_EN,
      PH_WAIT
   } xfer_phase_t;

   // Formatted character plus the blanking state that applies to the next digit.
   typedef struct packed {
      logic       blank;
      logic [7:0] ch;
   } digit_fmt_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] n);
      case (n)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_DISP_ON;
         2'd2:    return LCD_CLEAR;
         default: return LCD_ENTRY;
      endcase
   endfunction

   // An invalid digit prints '?' and, like any nonzero digit, ends blanking.
   // The least significant digit is never blanked.
   function automatic digit_fmt_t fmt_digit(input logic [3:0] d,
                                            input logic       blanking,
                                            input logic       is_ls);
      digit_fmt_t r;
      if (d > 4'd9) begin
         r.blank = 1'b0;
         r.ch    = ASCII_QMARK;
      end else if ((d == 4'd0) && blanking && !is_ls) begin
         r.blank = 1'b1;
         r.ch    = ASCII_SPACE;
      end else begin
         r.blank = 1'b0;
         r.ch    = ASCII_0 + {4'd0, d};
      end
      return r;
   endfunction

endpackage

// File: rtl/lcd_bcd_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_bcd_writer_if
// Host-side handshake between the binary-to-BCD stage and the LCD writer.
//   start : draw request (only honoured while busy=0)
//   sign  : 1 = negative value
//   bcd   : DIGITS BCD digits, index 0 = least significant
//   busy  : writer is initialising or drawing
//   done  : one-cycle pulse when a draw completes
// master = producer of the value, slave = lcd_bcd_writer.
// ---------------------------------------------------------------------------
interface lcd_bcd_writer_if #(
   parameter int DIGITS = 10
);
   logic       start;
   logic       sign;
   logic [3:0] bcd [DIGITS];
   logic       busy;
   logic       done;

   modport master (
      output start, sign, bcd,
      input  busy, done
   );

   modport slave (
      input  start, sign, bcd,
      output busy, done
   );
endinterface

// File: rtl/lcd_bcd_writer_xfer.sv
// ---------------------------------------------------------------------------
// lcd_byte_xfer
// Moves one byte onto the HD44780 8-bit bus with fixed timing:
//   cycle 0            SETUP : rs/data driven, en low
//   cycles 1..EN_CYC   EN    : en high
//   then WAIT cycles         : en low, CMD_WAIT_CYC or CLR_WAIT_CYC (long_wait)
// rs/data hold from SETUP to the end of WAIT (and afterwards until reloaded).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req, rs, data, long_wait byte request; accepted when idle or while ack=1
//   ack                     high in the last WAIT cycle; a req in that cycle
//                           starts the next byte with no gap
//   lcd_data/rs/rw/en       LCD bus (rw tied low)
// ---------------------------------------------------------------------------
module lcd_byte_xfer
   import lcd_pkg::*;
#(
   parameter int EN_CYC       = 12,
   parameter int CMD_WAIT_CYC = 2_500,
   parameter int CLR_WAIT_CYC = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       rs,
   input  logic [7:0] data,
   input  logic       long_wait,
   output logic       ack,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en
);

   localparam int MAX_A   = (EN_CYC > CMD_WAIT_CYC) ? EN_CYC : CMD_WAIT_CYC;
   localparam int MAX_CYC = (MAX_A > CLR_WAIT_CYC) ? MAX_A : CLR_WAIT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   xfer_phase_t      phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             long_q;
   logic             load;
   logic [CNT_W-1:0] wait_last;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   assign wait_last = long_q ? CLR_LAST : CMD_LAST;
   assign ack       = (phase_q == PH_WAIT) && (cnt_q == wait_last);
   assign lcd_rw    = 1'b0;

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (req) begin
               load    = 1'b1;
               phase_d = PH_SETUP;
            end
         end
         PH_SETUP: begin
            phase_d = PH_EN;
            cnt_d   = '0;
         end
         PH_EN: begin
            if (cnt_q == EN_LAST) begin
               phase_d = PH_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         default: begin
            if (ack) begin
               if (req) begin
                  load    = 1'b1;
                  phase_d = PH_SETUP;
               end else begin
                  phase_d = PH_IDLE;
               end
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
      endcase
   end

   // lcd_en is registered so the strobe is a clean flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= PH_IDLE;
         cnt_q    <= '0;
         long_q   <= 1'b0;
         lcd_data <= 8'h00;
         lcd_rs   <= 1'b0;
         lcd_en   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         lcd_en  <= (phase_d == PH_EN);
         if (load) begin
            long_q   <= long_wait;
            lcd_data <= data;
            lcd_rs   <= rs;
         end
      end
   end

endmodule

// File: rtl/lcd_bcd_writer.sv
// ---------------------------------------------------------------------------
// lcd_bcd_writer
// Writes a signed BCD value as ASCII to an HD44780 character LCD.
// After reset: wait PWRUP_CYC cycles, send 38/0C/01/06, then go idle.
// Each accepted start redraws one field: DDRAM address command, sign
// character, then DIGITS digits from most to least significant.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   host         lcd_bcd_writer_if.slave (start/sign/bcd in, busy/done out)
//   lcd_data     LCD data bus
//   lcd_rs       0 = command, 1 = data
//   lcd_rw       tied low
//   lcd_en       LCD enable strobe
// ---------------------------------------------------------------------------
module lcd_bcd_writer
   import lcd_pkg::*;
#(
   parameter int         DIGITS       = 10,
   parameter logic [6:0] LINE_ADDR    = 7'h00,
   parameter int         BLANK_LZ     = 1,
   parameter int         PWRUP_CYC    = 1_000_000,
   parameter int         EN_CYC       = 12,
   parameter int         CMD_WAIT_CYC = 2_500,
   parameter int         CLR_WAIT_CYC = 100_000
) (
   input  logic              clk,
   input  logic              rst_n,
   lcd_bcd_writer_if.slave   host,
   output logic [7:0]        lcd_data,
   output logic              lcd_rs,
   output logic              lcd_rw,
   output logic              lcd_en
);

   if ((DIGITS < 1) || (DIGITS + 1 > 16) || (PWRUP_CYC < 1) || (EN_CYC < 1) ||
       (CMD_WAIT_CYC < 1) || (CLR_WAIT_CYC < 1)) begin : g_param_chk
      $error("lcd_bcd_writer: need 1 <= DIGITS <= 15 and all cycle counts >= 1");
   end

   localparam int N_DRAW_BYTES = DIGITS + 2;
   localparam int IDX_MAX      = (N_DRAW_BYTES > N_INIT_CMDS) ? N_DRAW_BYTES : N_INIT_CMDS;
   localparam int IDX_W        = $clog2(IDX_MAX + 1);
   localparam int PW_W         = $clog2(PWRUP_CYC + 1);

   localparam logic [IDX_W-1:0] N_INIT  = IDX_W'(N_INIT_CMDS);
   localparam logic [IDX_W-1:0] N_DRAW  = IDX_W'(N_DRAW_BYTES);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PWRUP_CYC - 1);
   localparam logic [PW_W-1:0]  PW_MAX  = PW_W'(PWRUP_CYC);

   top_state_t       state_q, state_d;
   logic [PW_W-1:0]  pw_cnt_q;
   logic [IDX_W-1:0] idx_q, idx_d;   // index of the next byte to request
   logic             lz_q, lz_d;     // still inside the leading-zero run
   logic             busy_q, done_q;
   logic             latch;

   logic             sign_q;
   logic [3:0]       bcd_q [DIGITS];

   logic             req, req_rs, req_long, ack;
   logic [7:0]       req_data;
   logic [3:0]       cur_digit;
   int               dig;
   digit_fmt_t       fmt;

   assign host.busy = busy_q;
   assign host.done = done_q;

   // Digit for byte idx_q: byte 2 is the MS digit, byte DIGITS+1 the LS digit.
   always_comb begin
      dig       = DIGITS + 1 - int'(idx_q);
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i == dig) cur_digit = bcd_q[i];
      end
      fmt = fmt_digit(cur_digit, lz_q, dig == 0);
   end

   // Bytes are chained on ack so consecutive bytes run with no idle cycle;
   // the first byte of a burst is requested on the cycle that starts it.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lz_d     = lz_q;
      latch    = 1'b0;
      req      = 1'b0;
      req_rs   = 1'b0;
      req_data = 8'h00;
      case (state_q)
         ST_PWRUP: begin
            if (pw_cnt_q == PW_LAST) begin
               state_d  = ST_INIT;
               req      = 1'b1;
               req_data = init_cmd(2'd0);
               idx_d    = IDX_ONE;
            end
         end
         ST_INIT: begin
            if (ack) begin
               if (idx_q < N_INIT) begin
                  req      = 1'b1;
                  req_data = init_cmd(idx_q[1:0]);
                  idx_d    = idx_q + 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            if (host.start) begin
               latch    = 1'b1;
               state_d  = ST_DRAW;
               req      = 1'b1;
               req_data = LCD_SET_DDRAM | {1'b0, LINE_ADDR};
               idx_d    = IDX_ONE;
               lz_d     = (BLANK_LZ != 0);
            end
         end
         default: begin
            if (ack) begin
               if (idx_q < N_DRAW) begin
                  req    = 1'b1;
                  req_rs = 1'b1;
                  idx_d  = idx_q + 1'b1;
                  if (idx_q == IDX_ONE) begin
                     req_data = sign_q ? ASCII_MINUS : ASCII_SPACE;
                  end else begin
                     req_data = fmt.ch;
                     lz_d     = fmt.blank;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   assign req_long = !req_rs && (req_data == LCD_CLEAR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_PWRUP;
         pw_cnt_q <= '0;
         idx_q    <= '0;
         lz_q     <= 1'b0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lz_q    <= lz_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_q == ST_DRAW) && (state_d == ST_IDLE);
         if ((state_q == ST_PWRUP) && (pw_cnt_q != PW_MAX)) begin
            pw_cnt_q <= pw_cnt_q + 1'b1;
         end
      end
   end

   // Value snapshot taken at the accept edge; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (latch) begin
         sign_q <= host.sign;
         for (int i = 0; i < DIGITS; i++) begin
            bcd_q[i] <= host.bcd[i];
         end
      end
   end

   lcd_byte_xfer #(
      .EN_CYC       (EN_CYC),
      .CMD_WAIT_CYC (CMD_WAIT_CYC),
      .CLR_WAIT_CYC (CLR_WAIT_CYC)
   ) u_xfer (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .rs        (req_rs),
      .data      (req_data),
      .long_wait (req_long),
      .ack       (ack),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en)
   );

endmodule

// File: tb/tb_lcd_bcd_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_bcd_writer
// Two writers share one stimulus: dut1 with leading-zero blanking, dut0
// without. Every byte seen on each LCD bus is compared against a queue of
// expected {rs,data} values pushed when the stimulus is applied.
// ---------------------------------------------------------------------------
module tb_lcd_bcd_writer;

   localparam int DIGITS       = 4;
   localparam int PWRUP_CYC    = 10;
   localparam int EN_CYC       = 2;
   localparam int CMD_WAIT_CYC = 4;
   localparam int CLR_WAIT_CYC = 8;
   localparam int N_BYTES      = DIGITS + 2;
   localparam int BYTE_CYC     = 1 + EN_CYC + CMD_WAIT_CYC;
   localparam int INIT_LAT     = PWRUP_CYC + 3 * BYTE_CYC + (1 + EN_CYC + CLR_WAIT_CYC);
   localparam int DRAW_LAT     = N_BYTES * BYTE_CYC;

   typedef struct {
      logic        sign;
      logic [15:0] bcd;      // MS digit in [15:12]
      logic [47:0] exp_lz;   // six bytes, first byte in [47:40]
      logic [47:0] exp_nolz;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_s, sign_s;
   logic [15:0] bcd_s;
   logic [7:0]  d1, d0;
   logic        rs1, rs0, rw1, rw0, en1, en0;
   logic [8:0]  q1 [$];
   logic [8:0]  q0 [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        vecs [6];

   always #5 clk = ~clk;

   lcd_bcd_writer_if #(.DIGITS(DIGITS)) hif1 ();
   lcd_bcd_writer_if #(.DIGITS(DIGITS)) hif0 ();

   assign hif1.start = start_s;
   assign hif0.start = start_s;
   assign hif1.sign  = sign_s;
   assign hif0.sign  = sign_s;
   for (genvar g = 0; g < DIGITS; g++) begin : g_bcd
      assign hif1.bcd[g] = bcd_s[4*g +: 4];
      assign hif0.bcd[g] = bcd_s[4*g +: 4];
   end

   lcd_bcd_writer #(
      .DIGITS(DIGITS), .LINE_ADDR(7'h00), .BLANK_LZ(1), .PWRUP_CYC(PWRUP_CYC),
      .EN_CYC(EN_CYC), .CMD_WAIT_CYC(CMD_WAIT_CYC), .CLR_WAIT_CYC(CLR_WAIT_CYC)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .host(hif1),
      .lcd_data(d1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_en(en1)
   );

   lcd_bcd_writer #(
      .DIGITS(DIGITS), .LINE_ADDR(7'h00), .BLANK_LZ(0), .PWRUP_CYC(PWRUP_CYC),
      .EN_CYC(EN_CYC), .CMD_WAIT_CYC(CMD_WAIT_CYC), .CLR_WAIT_CYC(CLR_WAIT_CYC)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .host(hif0),
      .lcd_data(d0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_en(en0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_init();
      logic [7:0] cmds [4];
      cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
      for (int k = 0; k < 4; k++) begin
         q1.push_back({1'b0, cmds[k]});
         q0.push_back({1'b0, cmds[k]});
      end
   endtask

   task automatic push_draw(input logic [47:0] e1, input logic [47:0] e0);
      for (int k = 0; k < N_BYTES; k++) begin
         q1.push_back({(k != 0), e1[8*(N_BYTES-1-k) +: 8]});
         q0.push_back({(k != 0), e0[8*(N_BYTES-1-k) +: 8]});
      end
   endtask

   // Bus monitor: one comparison per byte at the rising strobe, plus strobe width.
   initial begin : monitor
      logic       p1, p0;
      int         h1, h0;
      logic [8:0] e;
      p1 = 1'b0; p0 = 1'b0; h1 = 0; h0 = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p1 = 1'b0; p0 = 1'b0; h1 = 0; h0 = 0;
         end else begin
            if (en1 && !p1) begin
               if (q1.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL dut1 unexpected byte: got rs=%0b data=0x%0h, want none", rs1, d1);
               end else begin
                  e = q1.pop_front();
                  chk("dut1 byte {rs,data}", {23'd0, rs1, d1}, {23'd0, e});
                  chk("dut1 lcd_rw", {31'd0, rw1}, 32'd0);
               end
            end
            if (en0 && !p0) begin
               if (q0.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL dut0 unexpected byte: got rs=%0b data=0x%0h, want none", rs0, d0);
               end else begin
                  e = q0.pop_front();
                  chk("dut0 byte {rs,data}", {23'd0, rs0, d0}, {23'd0, e});
               end
            end
            if (en1) h1++;
            else if (p1) begin chk("dut1 en width", h1, EN_CYC); h1 = 0; end
            if (en0) h0++;
            else if (p0) begin chk("dut0 en width", h0, EN_CYC); h0 = 0; end
            p1 = en1;
            p0 = en0;
         end
      end
   end

   // Releases reset and waits for busy to fall, pulsing start on two cycles.
   task automatic run_init(input int pa, input int pb);
      int   cyc;
      logic saw_done;
      push_init();
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      saw_done = 1'b0;
      while (cyc < 300) begin
         @(posedge clk);
         cyc++;
         #1;
         if (hif1.done || hif0.done) saw_done = 1'b1;
         if (!hif1.busy) break;
         start_s = (cyc == pa) || (cyc == pb);
      end
      start_s = 1'b0;
      chk("init busy-fall cycle", cyc, INIT_LAT);
      chk("init done stays low", {31'd0, saw_done}, 32'd0);
      chk("dut0 idle after init", {31'd0, hif0.busy}, 32'd0);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (cyc < 500) begin
         @(posedge clk);
         cyc++;
         #1;
         if (hif1.done) break;
      end
   endtask

   task automatic accept(input logic s, input logic [15:0] b);
      @(negedge clk);
      sign_s  = s;
      bcd_s   = b;
      start_s = 1'b1;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      chk("busy after accept", {31'd0, hif1.busy}, 32'd1);
   endtask

   task automatic finish_draw(input string tag, input int offset);
      int cyc;
      wait_done(cyc);
      chk({tag, " done latency"}, cyc + offset, DRAW_LAT);
      chk({tag, " dut0 done"}, {31'd0, hif0.done}, 32'd1);
      chk({tag, " busy low on done"}, {31'd0, hif1.busy}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " done one cycle"}, {31'd0, hif1.done}, 32'd0);
   endtask

   initial begin : main
      int   cyc;
      int   rises;
      logic prev;

      vecs[0] = '{1'b0, 16'h0123, 48'h80_20_20_31_32_33, 48'h80_20_30_31_32_33};
      vecs[1] = '{1'b1, 16'h0000, 48'h80_2D_20_20_20_30, 48'h80_2D_30_30_30_30};
      vecs[2] = '{1'b0, 16'h0A05, 48'h80_20_20_3F_30_35, 48'h80_20_30_3F_30_35};
      vecs[3] = '{1'b1, 16'h9876, 48'h80_2D_39_38_37_36, 48'h80_2D_39_38_37_36};
      vecs[4] = '{1'b0, 16'h00F0, 48'h80_20_20_20_3F_30, 48'h80_20_30_30_3F_30};
      vecs[5] = '{1'b0, 16'h0007, 48'h80_20_20_20_20_37, 48'h80_20_30_30_30_37};

      start_s = 1'b0;
      sign_s  = 1'b0;
      bcd_s   = 16'h0000;

      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, hif1.busy}, 32'd1);
      chk("reset done", {31'd0, hif1.done}, 32'd0);
      chk("reset lcd_en", {31'd0, en1}, 32'd0);
      chk("reset lcd_data", {24'd0, d1}, 32'd0);
      chk("reset lcd_rs", {31'd0, rs1}, 32'd0);
      chk("reset lcd_rw", {31'd0, rw1}, 32'd0);

      // Start pulses during PWRUP (cycle 5) and INIT (cycle 20) must be dropped.
      run_init(5, 20);
      repeat (20) @(posedge clk);
      #1;
      chk("start during init ignored", {31'd0, hif1.busy}, 32'd0);

      for (int v = 0; v < 6; v++) begin
         push_draw(vecs[v].exp_lz, vecs[v].exp_nolz);
         accept(vecs[v].sign, vecs[v].bcd);
         finish_draw("vector", 0);
         repeat (3) @(posedge clk);
      end

      // Inputs and a new start during DRAW must not disturb the field.
      push_draw(vecs[0].exp_lz, vecs[0].exp_nolz);
      accept(vecs[0].sign, vecs[0].bcd);
      repeat (15) @(posedge clk);
      #1;
      start_s = 1'b1;
      sign_s  = 1'b1;
      bcd_s   = 16'h9999;
      @(posedge clk);
      #1;
      start_s = 1'b0;
      finish_draw("mid-draw change", 16);
      repeat (20) @(posedge clk);
      #1;
      chk("start mid-draw ignored", {31'd0, hif1.busy}, 32'd0);

      // start held high: the done cycle accepts the next draw.
      push_draw(vecs[3].exp_lz, vecs[3].exp_nolz);
      push_draw(vecs[3].exp_lz, vecs[3].exp_nolz);
      @(negedge clk);
      sign_s  = vecs[3].sign;
      bcd_s   = vecs[3].bcd;
      start_s = 1'b1;
      @(posedge clk);
      #1;
      chk("held start accept", {31'd0, hif1.busy}, 32'd1);
      wait_done(cyc);
      chk("held start first latency", cyc, DRAW_LAT);
      @(posedge clk);
      #1;
      start_s = 1'b0;
      chk("redraw accepted on done cycle", {31'd0, hif1.busy}, 32'd1);
      finish_draw("held start second", 0);
      chk("idle after held start", {31'd0, hif1.busy}, 32'd0);

      // Reset during the enable phase of the third draw byte.
      push_draw(vecs[0].exp_lz, vecs[0].exp_nolz);
      accept(vecs[0].sign, vecs[0].bcd);
      rises = 0;
      prev  = en1;
      cyc   = 0;
      while ((rises < 3) && (cyc < 200)) begin
         @(posedge clk);
         cyc++;
         #1;
         if (en1 && !prev) rises++;
         prev = en1;
      end
      chk("third byte strobe reached", rises, 3);
      rst_n = 1'b0;
      #1;
      chk("async reset drops dut1 lcd_en", {31'd0, en1}, 32'd0);
      chk("async reset drops dut0 lcd_en", {31'd0, en0}, 32'd0);
      chk("async reset busy", {31'd0, hif1.busy}, 32'd1);
      chk("async reset lcd_data", {24'd0, d1}, 32'd0);
      q1.delete();
      q0.delete();
      repeat (2) @(posedge clk);
      run_init(-1, -1);
      repeat (3) @(posedge clk);
      push_draw(vecs[2].exp_lz, vecs[2].exp_nolz);
      accept(vecs[2].sign, vecs[2].bcd);
      finish_draw("after reset", 0);

      repeat (5) @(posedge clk);
      chk("dut1 bytes outstanding", q1.size(), 0);
      chk("dut0 bytes outstanding", q0.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
